// File: rtl/neosd_cmd_if.sv
// Register-file side of the neosd CMD engine: command request, live divider and status/response.
interface neosd_cmd_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] div_i;
  logic             start_i;
  logic [5:0]       cmd_idx_i;
  logic [31:0]      cmd_arg_i;
  logic [1:0]       rsp_type_i;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic             crc_err_o;
  logic [135:0]     rsp_o;

  modport master (
    output div_i, start_i, cmd_idx_i, cmd_arg_i, rsp_type_i,
    input  busy_o, done_o, timeout_o, crc_err_o, rsp_o
  );

  modport slave (
    input  div_i, start_i, cmd_idx_i, cmd_arg_i, rsp_type_i,
    output busy_o, done_o, timeout_o, crc_err_o, rsp_o
  );
endinterface

// File: rtl/neosd_cmd_engine.sv
// SD CMD-line sequencer: sd_clk divider, 48-bit command TX with CRC7, response capture, NCC gap.
//
// state  | meaning
// S_IDLE | CMD released, waiting for start_i
// S_TX   | shifting the 48-bit command frame out on FALL events
// S_WAIT | sampling CMD on RISE events for the response start bit
// S_RX   | shifting the response in on RISE events
// S_NCC  | 8 FALL events with CMD released, then done pulse
module neosd_cmd_engine #(
  parameter int DIV_W   = 8,
  parameter int NCR_MAX = 64
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  neosd_cmd_if.slave    bus,
  output logic          sd_clk_o,
  output logic          sd_cmd_o,
  input  logic          sd_cmd_i,
  output logic          sd_cmd_oe
);

  localparam int NCR_W = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_NCC} state_t;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             sd_clk_q;
  logic             tick, fall_evt, rise_evt;
  logic [47:0]      tx_sr;
  logic [5:0]       tx_left;
  logic [7:0]       rx_left;
  logic [NCR_W-1:0] ncr_left;
  logic [2:0]       ncc_left;
  logic             rsp_en, rsp_long;
  logic             busy_q, done_q, timeout_q, crc_err_q;
  logic [135:0]     rsp_q;
  logic [135:0]     rsp_next;
  logic             cmd_q, oe_q;

  assign tick     = (div_cnt >= bus.div_i);
  assign fall_evt = tick & sd_clk_q;
  assign rise_evt = tick & ~sd_clk_q;
  assign rsp_next = {rsp_q[134:0], sd_cmd_i};

  // >= rather than == so a live shrink of div_i never lets the counter run away
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_cnt  <= '0;
      sd_clk_q <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      sd_clk_q <= ~sd_clk_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      tx_sr     <= '0;
      tx_left   <= '0;
      rx_left   <= '0;
      ncr_left  <= '0;
      ncc_left  <= '0;
      rsp_en    <= 1'b0;
      rsp_long  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      rsp_q     <= '0;
      cmd_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_q <= 1'b1;
          oe_q  <= 1'b0;
          if (bus.start_i) begin
            tx_sr     <= {2'b01, bus.cmd_idx_i, bus.cmd_arg_i,
                          crc7({2'b01, bus.cmd_idx_i, bus.cmd_arg_i}), 1'b1};
            tx_left   <= 6'd48;
            rsp_en    <= (bus.rsp_type_i == 2'd1) || (bus.rsp_type_i == 2'd2);
            rsp_long  <= (bus.rsp_type_i == 2'd2);
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            rsp_q     <= '0;
            busy_q    <= 1'b1;
            state     <= S_TX;
          end
        end
        S_TX: begin
          if (fall_evt) begin
            if (tx_left != 6'd0) begin
              cmd_q   <= tx_sr[47];
              oe_q    <= 1'b1;
              tx_sr   <= {tx_sr[46:0], 1'b0};
              tx_left <= tx_left - 6'd1;
            end else begin
              cmd_q    <= 1'b1;
              oe_q     <= 1'b0;
              ncr_left <= NCR_W'(NCR_MAX - 1);
              ncc_left <= 3'd7;
              state    <= rsp_en ? S_WAIT : S_NCC;
            end
          end
        end
        S_WAIT: begin
          if (rise_evt) begin
            if (!sd_cmd_i) begin
              rsp_q   <= rsp_next;
              rx_left <= rsp_long ? 8'd135 : 8'd47;
              state   <= S_RX;
            end else if (ncr_left == '0) begin
              timeout_q <= 1'b1;
              ncc_left  <= 3'd7;
              state     <= S_NCC;
            end else begin
              ncr_left <= ncr_left - 1'b1;
            end
          end
        end
        S_RX: begin
          if (rise_evt) begin
            rsp_q <= rsp_next;
            if (rx_left == 8'd1) begin
              // the last bit is still on the pin, so check the frame as it will be stored
              crc_err_q <= rsp_long ? ~sd_cmd_i
                         : ((crc7(rsp_next[47:8]) != rsp_next[7:1]) | ~sd_cmd_i);
              ncc_left  <= 3'd7;
              state     <= S_NCC;
            end else begin
              rx_left <= rx_left - 8'd1;
            end
          end
        end
        S_NCC: begin
          // busy stays high through the done cycle so a start_i there is dropped
          if (done_q) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (fall_evt) begin
            if (ncc_left == 3'd0) done_q <= 1'b1;
            else                  ncc_left <= ncc_left - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.timeout_o = timeout_q;
  assign bus.crc_err_o = crc_err_q;
  assign bus.rsp_o     = rsp_q;
  assign sd_clk_o      = sd_clk_q;
  assign sd_cmd_o      = cmd_q;
  assign sd_cmd_oe     = oe_q;

endmodule
